fwrisc_ifetch_buf: RTL

FWRISC_IFETCH_BUF -- requirements
Module: fwrisc_ifetch_buf

---
 rtl/fwrisc_pkg.sv | 34 +++
 rtl/fwrisc_ifetch_fifo.sv | 75 +++++++
 rtl/fwrisc_ifetch_buf.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fwrisc_pkg.sv
// Shared constants and helpers for the FWRISC instruction-fetch path.
// Holds the default reset vector and the default prefetch depth used by
// fwrisc_ifetch_buf, plus small address helpers.
package fwrisc_pkg;

    // Default first fetch address after reset
    localparam logic [31:0] FWRISC_RESET_VECTOR = 32'h0000_0000;

    // Default number of prefetch buffer entries
    localparam int FWRISC_IFETCH_DEPTH = 4;

    // Size of one instruction word in bytes
    localparam logic [31:0] FWRISC_INSN_BYTES = 32'd4;

    // What the fetch buffer does with the core request in a given cycle
    typedef enum logic [1:0] {
        IFB_IDLE     = 2'd0,  // no delivery, no redirect (includes waiting)
        IFB_HIT      = 2'd1,  // deliver FIFO head
        IFB_BYPASS   = 2'd2,  // deliver the response arriving this cycle
        IFB_REDIRECT = 2'd3   // core asked for a non-sequential address
    } ifb_action_e;

    // Force an address onto a word boundary
    function automatic logic [31:0] fwrisc_word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // True when two byte addresses refer to the same instruction word
    function automatic logic fwrisc_same_word(input logic [31:0] a,
                                              input logic [31:0] b);
        return (a[31:2] == b[31:2]);
    endfunction

endpackage

// File: rtl/fwrisc_ifetch_fifo.sv
// Circular instruction buffer for fwrisc_ifetch_buf.
// DEPTH x WIDTH storage with push/pop/flush and an occupancy count.
// The head entry is read combinationally so a hit can be returned in the
// same cycle it is requested. Pointers wrap naturally modulo DEPTH
// (DEPTH is a power of two). Pushing while full is never requested by
// the controller and is not guarded here.
module fwrisc_ifetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    // Next pointer/count values; flush empties the buffer outright
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers, cleared by the active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clock) begin
        if (push && !flush && reset) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fwrisc_ifetch_buf.sv
// Instruction prefetch buffer sitting between the FWRISC core fetch port
// and a pipelined memory read port.
// Requests run ahead of the core while buffer space (entries plus
// in-flight reads not yet marked for discard) allows. A sequential fetch
// that matches the buffered stream completes in the same cycle; any other
// address redirects the stream and discards every read still in flight.
// Optional feature macro: FWRISC_IFETCH_BUF_BYPASS_EN -- lets a response
// arriving into an empty buffer go straight to the core in that cycle.
module fwrisc_ifetch_buf
    import fwrisc_pkg::*;
#(
    parameter int          DEPTH        = FWRISC_IFETCH_DEPTH,
    parameter logic [31:0] RESET_VECTOR = FWRISC_RESET_VECTOR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] iaddr,
    input  logic        ivalid,
    output logic [31:0] idata,
    output logic        iready,
    output logic [31:0] maddr,
    output logic        mvalid,
    input  logic        mready,
    input  logic [31:0] mrdata,
    input  logic        mrvalid
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;
    localparam logic [31:0] RESET_ADDR = fwrisc_word_align(RESET_VECTOR);

`ifdef FWRISC_IFETCH_BUF_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic [31:0]  fetch_addr_q, fetch_addr_d;
    logic [31:0]  exp_addr_q,   exp_addr_d;
    logic [CW-1:0] outst_q,     outst_d;
    logic [CW-1:0] drop_q,      drop_d;

    logic [CW-1:0] fifo_count;
    logic [31:0]   fifo_head;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;

    ifb_action_e   action;
    logic          fifo_empty;
    logic          drop_pending;
    logic          resp;
    logic          accept;
    logic [SW-1:0] occupancy;
    logic          can_issue;

    // Decide what happens to the core request this cycle
    always_comb begin
        fifo_empty   = (fifo_count == '0);
        drop_pending = (drop_q != '0);
        action       = IFB_IDLE;
        if (reset && ivalid) begin
            if (!fwrisc_same_word(iaddr, exp_addr_q)) begin
                action = IFB_REDIRECT;
            end else if (!fifo_empty) begin
                action = IFB_HIT;
            end else if (BYPASS_EN && !drop_pending && mrvalid) begin
                action = IFB_BYPASS;
            end
        end
    end

    // Memory request side: issue while the buffer can absorb the response
    always_comb begin
        occupancy = SW'(fifo_count) + SW'(outst_q) - SW'(drop_q);
        can_issue = (occupancy < SW'(DEPTH));
        mvalid    = reset && (action != IFB_REDIRECT) && can_issue;
        maddr     = reset ? fetch_addr_q : RESET_ADDR;
        accept    = mvalid && mready;
    end

    // Response routing and core-side outputs
    always_comb begin
        resp       = reset && mrvalid;
        fifo_push  = resp && !drop_pending
                     && (action != IFB_REDIRECT) && (action != IFB_BYPASS);
        fifo_pop   = (action == IFB_HIT);
        fifo_flush = (action == IFB_REDIRECT);
        iready     = (action == IFB_HIT) || (action == IFB_BYPASS);
        case (action)
            IFB_HIT:    idata = fifo_head;
            IFB_BYPASS: idata = mrdata;
            default:    idata = 32'h0;
        endcase
    end

    // Next-state for addresses and in-flight bookkeeping
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        exp_addr_d   = exp_addr_q;
        outst_d      = outst_q;
        drop_d       = drop_q;

        if (accept) begin
            outst_d = outst_d + 1'b1;
        end
        if (resp) begin
            outst_d = outst_d - 1'b1;
        end

        if (action == IFB_REDIRECT) begin
            // Everything still in flight after this cycle belongs to the
            // old stream; a response landing now is discarded as well.
            drop_d       = outst_d;
            fetch_addr_d = fwrisc_word_align(iaddr);
            exp_addr_d   = fwrisc_word_align(iaddr);
        end else begin
            if (resp && drop_pending) begin
                drop_d = drop_q - 1'b1;
            end
            if (accept) begin
                fetch_addr_d = fetch_addr_q + FWRISC_INSN_BYTES;
            end
            if (iready) begin
                exp_addr_d = exp_addr_q + FWRISC_INSN_BYTES;
            end
        end
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_addr_q <= RESET_ADDR;
            exp_addr_q   <= RESET_ADDR;
            outst_q      <= '0;
            drop_q       <= '0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            exp_addr_q   <= exp_addr_d;
            outst_q      <= outst_d;
            drop_q       <= drop_d;
        end
    end

    fwrisc_ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .wdata (mrdata),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .count (fifo_count)
    );

endmodule
